// File: rtl/mem_stage_access_pkg.sv
// Shared constants and types for the MEM stage: datapath widths, FSM encoding, timeout default.
// Combinational helper classifies an EX/MEM memory request as illegal.
package mem_stage_access_pkg;
    localparam int N                   = 32;
    localparam int REG_FILE_ADDR_LEN   = 5;
    localparam int MEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {MS_IDLE, MS_REQ, MS_WAIT} mem_state_t;

    // Loads and stores are word-only; asking for both at once is meaningless.
    function automatic logic is_illegal(input logic rd, input logic wr, input logic [1:0] lsb);
        return (rd & wr) | ((rd | wr) & (lsb != 2'b00));
    endfunction
endpackage

// File: rtl/mem_stage_access_if.sv
// req/gnt/rvalid data-memory bus. master = MEM stage, slave = memory.
interface mem_stage_access_if;
    logic                          req;
    logic                          we;
    logic [mem_stage_access_pkg::N-1:0] addr;
    logic [mem_stage_access_pkg::N-1:0] wdata;
    logic                          gnt;
    logic                          rvalid;
    logic [mem_stage_access_pkg::N-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_access_watchdog.sv
// Access watchdog: counts busy cycles, flags the cycle in which the LIMIT-th busy cycle occurs.
// Zero latency on tc; no backpressure.
module mem_stage_access_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = en && (count == W'(LIMIT - 1));
endmodule

// File: rtl/mem_stage_access.sv
// MEM stage + MEM/WB register: runs loads/stores on the memory bus, 1-cycle latency for non-memory ops.
// Freezes upstream combinationally while an access is in flight; aborts with mem_err on timeout.
module mem_stage_access
    import mem_stage_access_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         WB_EN_IN,
    input  logic                         MEM_R_EN_IN,
    input  logic                         MEM_W_EN_IN,
    input  logic [N-1:0]                 PCIn,
    input  logic [N-1:0]                 ALUResIn,
    input  logic [N-1:0]                 STValIn,
    input  logic [REG_FILE_ADDR_LEN-1:0] destIn,
    mem_stage_access_if.master           mem,
    output logic                         mem_freeze,
    output logic                         mem_err,
    output logic                         WB_EN,
    output logic                         MEM_R_EN,
    output logic [N-1:0]                 PC,
    output logic [N-1:0]                 ALURes,
    output logic [N-1:0]                 MEMRes,
    output logic [REG_FILE_ADDR_LEN-1:0] dest
);
    mem_state_t state, state_nxt;

    logic                         cap_wb, cap_w;
    logic [N-1:0]                 cap_pc, cap_addr, cap_wdata;
    logic [REG_FILE_ADDR_LEN-1:0] cap_dest;

    logic is_mem_op, illegal, accept, tc;
    logic done_store, done_load, abort;

    assign is_mem_op = MEM_R_EN_IN | MEM_W_EN_IN;
    assign illegal   = is_illegal(MEM_R_EN_IN, MEM_W_EN_IN, ALUResIn[1:0]);
    assign accept    = (state == MS_IDLE) && is_mem_op && !illegal;

    mem_stage_access_watchdog #(.LIMIT(MEM_TIMEOUT)) u_watchdog (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .en   (state != MS_IDLE),
        .tc   (tc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= MS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion beats timeout when both land in the same cycle, except a load gnt,
    // which would still need a WAIT cycle the watchdog no longer allows.
    always_comb begin
        state_nxt  = state;
        mem_freeze = 1'b0;
        done_store = 1'b0;
        done_load  = 1'b0;
        abort      = 1'b0;
        case (state)
            MS_IDLE: begin
                if (accept) begin
                    mem_freeze = 1'b1;
                    state_nxt  = MS_REQ;
                end
            end
            MS_REQ: begin
                if (mem.gnt && cap_w) begin
                    done_store = 1'b1;
                    state_nxt  = MS_IDLE;
                end else if (tc) begin
                    abort     = 1'b1;
                    state_nxt = MS_IDLE;
                end else begin
                    mem_freeze = 1'b1;
                    if (mem.gnt) begin
                        state_nxt = MS_WAIT;
                    end
                end
            end
            MS_WAIT: begin
                if (mem.rvalid) begin
                    done_load = 1'b1;
                    state_nxt = MS_IDLE;
                end else if (tc) begin
                    abort     = 1'b1;
                    state_nxt = MS_IDLE;
                end else begin
                    mem_freeze = 1'b1;
                end
            end
            default: state_nxt = MS_IDLE;
        endcase
    end

    assign mem.req   = (state == MS_REQ);
    assign mem.we    = cap_w;
    assign mem.addr  = cap_addr;
    assign mem.wdata = cap_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_wb    <= 1'b0;
            cap_w     <= 1'b0;
            cap_pc    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_dest  <= '0;
        end else if (accept) begin
            cap_wb    <= WB_EN_IN;
            cap_w     <= MEM_W_EN_IN;
            cap_pc    <= PCIn;
            cap_addr  <= ALUResIn;
            cap_wdata <= STValIn;
            cap_dest  <= destIn;
        end
    end

    // Default is a bubble: enables drop, data fields hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            PC       <= '0;
            ALURes   <= '0;
            MEMRes   <= '0;
            dest     <= '0;
            mem_err  <= 1'b0;
        end else begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            mem_err  <= 1'b0;
            if (state == MS_IDLE && !is_mem_op) begin
                WB_EN  <= WB_EN_IN;
                PC     <= PCIn;
                ALURes <= ALUResIn;
                MEMRes <= '0;
                dest   <= destIn;
            end else if (state == MS_IDLE && illegal) begin
                PC      <= PCIn;
                ALURes  <= ALUResIn;
                MEMRes  <= '0;
                dest    <= destIn;
                mem_err <= 1'b1;
            end else if (done_store || done_load) begin
                WB_EN    <= cap_wb;
                MEM_R_EN <= done_load;
                PC       <= cap_pc;
                ALURes   <= cap_addr;
                MEMRes   <= done_load ? mem.rdata : '0;
                dest     <= cap_dest;
            end else if (abort) begin
                mem_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: scoreboard of expected WB-stage outputs plus inline bus/freeze checks.
module tb_mem_stage_access;
    import mem_stage_access_pkg::*;

    logic                         clk;
    logic                         rstn;
    logic                         WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
    logic [N-1:0]                 PCIn, ALUResIn, STValIn;
    logic [REG_FILE_ADDR_LEN-1:0] destIn;
    logic                         mem_freeze, mem_err, WB_EN, MEM_R_EN;
    logic [N-1:0]                 PC, ALURes, MEMRes;
    logic [REG_FILE_ADDR_LEN-1:0] dest;

    mem_stage_access_if mem_if();

    mem_stage_access #(.MEM_TIMEOUT(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .WB_EN_IN    (WB_EN_IN),
        .MEM_R_EN_IN (MEM_R_EN_IN),
        .MEM_W_EN_IN (MEM_W_EN_IN),
        .PCIn        (PCIn),
        .ALUResIn    (ALUResIn),
        .STValIn     (STValIn),
        .destIn      (destIn),
        .mem         (mem_if),
        .mem_freeze  (mem_freeze),
        .mem_err     (mem_err),
        .WB_EN       (WB_EN),
        .MEM_R_EN    (MEM_R_EN),
        .PC          (PC),
        .ALURes      (ALURes),
        .MEMRes      (MEMRes),
        .dest        (dest)
    );

    typedef struct {
        logic                         wb;
        logic                         rd;
        logic                         err;
        logic                         full;
        logic [N-1:0]                 pc;
        logic [N-1:0]                 alu;
        logic [N-1:0]                 memres;
        logic [REG_FILE_ADDR_LEN-1:0] dst;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wb, input logic rd, input logic err, input logic full,
                        input logic [N-1:0] pc, input logic [N-1:0] alu,
                        input logic [N-1:0] mres, input logic [REG_FILE_ADDR_LEN-1:0] dst);
        exp_t e;
        e.wb = wb; e.rd = rd; e.err = err; e.full = full;
        e.pc = pc; e.alu = alu; e.memres = mres; e.dst = dst;
        sb.push_back(e);
    endtask

    // Any cycle where WB_EN or mem_err is high is an output event owed to the scoreboard.
    task automatic monitor();
        exp_t e;
        if (WB_EN === 1'b1 || mem_err === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'({WB_EN, mem_err}), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("out_wb_en", 64'(WB_EN), 64'(e.wb));
                chk("out_mem_r_en", 64'(MEM_R_EN), 64'(e.rd));
                chk("out_mem_err", 64'(mem_err), 64'(e.err));
                if (e.full) begin
                    chk("out_pc", 64'(PC), 64'(e.pc));
                    chk("out_alures", 64'(ALURes), 64'(e.alu));
                    chk("out_memres", 64'(MEMRes), 64'(e.memres));
                    chk("out_dest", 64'(dest), 64'(e.dst));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic drive(input logic wb, input logic r, input logic w, input logic [N-1:0] pc,
                         input logic [N-1:0] alu, input logic [N-1:0] st,
                         input logic [REG_FILE_ADDR_LEN-1:0] dst);
        WB_EN_IN = wb; MEM_R_EN_IN = r; MEM_W_EN_IN = w;
        PCIn = pc; ALUResIn = alu; STValIn = st; destIn = dst;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 32'hCAFE, 32'h44, 32'h0, 5'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wb_en"}, 64'(WB_EN), 64'(0));
        chk({tag, "_mem_r_en"}, 64'(MEM_R_EN), 64'(0));
        chk({tag, "_pc"}, 64'(PC), 64'(0));
        chk({tag, "_alures"}, 64'(ALURes), 64'(0));
        chk({tag, "_memres"}, 64'(MEMRes), 64'(0));
        chk({tag, "_dest"}, 64'(dest), 64'(0));
        chk({tag, "_mem_err"}, 64'(mem_err), 64'(0));
        chk({tag, "_mem_req"}, 64'(mem_if.req), 64'(0));
        chk({tag, "_freeze"}, 64'(mem_freeze), 64'(0));
    endtask

    initial begin
        int req_cycles;
        logic released;

        rstn = 1'b0;
        nop();
        mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rstn = 1'b1;
        tick();

        // 1: plain ALU op passes through with one cycle of latency
        drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h1234, 32'h0, 5'd5);
        push(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h1234, 32'h0, 5'd5);
        #1;
        chk("alu_freeze", 64'(mem_freeze), 64'(0));
        chk("alu_req", 64'(mem_if.req), 64'(0));
        tick();
        nop();
        tick();

        // 2: load, gnt on third REQ cycle, rvalid on third WAIT cycle; stray rvalid in REQ
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h100, 32'h0, 5'd7);
        push(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h100, 32'hDEADBEEF, 5'd7);
        #1;
        chk("ld_accept_freeze", 64'(mem_freeze), 64'(1));
        chk("ld_accept_req", 64'(mem_if.req), 64'(0));
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h999, 32'h999, 32'h999, 5'd31);
        for (int i = 0; i < 3; i++) begin
            mem_if.gnt    = (i == 2);
            mem_if.rvalid = (i == 0);
            mem_if.rdata  = 32'h0BAD0BAD;
            #1;
            chk("ld_req", 64'(mem_if.req), 64'(1));
            chk("ld_we", 64'(mem_if.we), 64'(0));
            chk("ld_addr", 64'(mem_if.addr), 64'(32'h100));
            chk("ld_req_freeze", 64'(mem_freeze), 64'(1));
            tick();
        end
        mem_if.gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_if.rvalid = (i == 2);
            mem_if.rdata  = (i == 2) ? 32'hDEADBEEF : 32'h0;
            if (i == 2) nop();
            #1;
            chk("ld_wait_req", 64'(mem_if.req), 64'(0));
            chk("ld_wait_freeze", 64'(mem_freeze), 64'(i != 2));
            tick();
        end
        mem_if.rvalid = 1'b0;

        // 3: store granted on first REQ cycle
        drive(1'b1, 1'b0, 1'b1, 32'h30, 32'h40, 32'hA5A5A5A5, 5'd9);
        push(1'b1, 1'b0, 1'b0, 1'b1, 32'h30, 32'h40, 32'h0, 5'd9);
        #1;
        chk("st_accept_freeze", 64'(mem_freeze), 64'(1));
        tick();
        nop();
        mem_if.gnt = 1'b1;
        #1;
        chk("st_req", 64'(mem_if.req), 64'(1));
        chk("st_we", 64'(mem_if.we), 64'(1));
        chk("st_addr", 64'(mem_if.addr), 64'(32'h40));
        chk("st_wdata", 64'(mem_if.wdata), 64'(32'hA5A5A5A5));
        chk("st_gnt_freeze", 64'(mem_freeze), 64'(0));
        tick();
        mem_if.gnt = 1'b0;
        #1;
        chk("st_done_req", 64'(mem_if.req), 64'(0));

        // 4: misaligned load, then read+write together
        drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h102, 32'h0, 5'd3);
        push(1'b0, 1'b0, 1'b1, 1'b1, 32'h50, 32'h102, 32'h0, 5'd3);
        #1;
        chk("misal_freeze", 64'(mem_freeze), 64'(0));
        tick();
        chk("misal_req", 64'(mem_if.req), 64'(0));
        drive(1'b1, 1'b1, 1'b1, 32'h60, 32'h200, 32'h0, 5'd4);
        push(1'b0, 1'b0, 1'b1, 1'b1, 32'h60, 32'h200, 32'h0, 5'd4);
        #1;
        chk("rw_freeze", 64'(mem_freeze), 64'(0));
        tick();
        chk("rw_req", 64'(mem_if.req), 64'(0));
        nop();
        tick();
        chk("err_one_cycle", 64'(mem_err), 64'(0));

        // 5: load that is never granted times out after 8 REQ cycles
        drive(1'b1, 1'b1, 1'b0, 32'h70, 32'h80, 32'h0, 5'd2);
        push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        nop();
        req_cycles = 0;
        released   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_if.req !== 1'b1) break;
            req_cycles++;
            if (mem_freeze === 1'b0) begin
                released = 1'b1;
                chk("to_release_cycle", 64'(i), 64'(7));
            end
            tick();
        end
        chk("to_req_cycles", 64'(req_cycles), 64'(8));
        chk("to_released", 64'(released), 64'(1));
        tick();
        chk("to_err_one_cycle", 64'(mem_err), 64'(0));
        chk("to_idle_freeze", 64'(mem_freeze), 64'(0));

        // 6: reset while waiting for load data; late rvalid/gnt ignored
        drive(1'b1, 1'b1, 1'b0, 32'h90, 32'h90, 32'h0, 5'd6);
        tick();
        nop();
        mem_if.gnt = 1'b1;
        #1;
        tick();
        mem_if.gnt = 1'b0;
        #1;
        chk("rst_pre_wait_freeze", 64'(mem_freeze), 64'(1));
        chk("rst_pre_pc", 64'(PC), 64'(32'hCAFE));
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_if.rvalid = 1'b1;
            mem_if.gnt    = 1'b1;
            mem_if.rdata  = 32'h00BADBAD;
            #1;
            chk("post_rst_req", 64'(mem_if.req), 64'(0));
            chk("post_rst_freeze", 64'(mem_freeze), 64'(0));
            tick();
            chk("post_rst_mem_r_en", 64'(MEM_R_EN), 64'(0));
            chk("post_rst_memres", 64'(MEMRes), 64'(0));
        end
        mem_if.rvalid = 1'b0;
        mem_if.gnt    = 1'b0;
        tick();

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
